// File: rtl/mod_time_counter_pkg.sv
// Shared stopwatch definitions: BCD digit layout, encoding selectors and
// default terminal values for the seconds and minutes stages.
package mod_time_counter_pkg;

    localparam int ENC_BINARY = 0;
    localparam int ENC_BCD    = 1;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_UNITS_LSB = 0;
    localparam int BCD_TENS_LSB  = 4;

    localparam int MAX_SECONDS = 59;
    localparam int MAX_MINUTES = 99;

    // Terminal value expressed in the counter's active encoding.
    function automatic int max_to_enc(input int max_val, input int bcd);
        if (bcd == ENC_BCD)
            return ((max_val / 10) << BCD_TENS_LSB) | (max_val % 10);
        return max_val;
    endfunction

endpackage

// File: rtl/mod_time_counter_step.sv
// Combinational one-step successor/predecessor of a modulo counter value,
// with the at-terminal flag used for carry/borrow cascading.
module mod_step
    import mod_time_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BCD   = ENC_BINARY
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] max_enc,
    output logic [WIDTH-1:0] nxt,
    output logic             at_term
);

    assign at_term = up_dn ? (cur == max_enc) : (cur == '0);

    generate
        if (BCD == ENC_BCD) begin : g_bcd
            logic [3:0]       units;
            logic [3:0]       tens;
            logic [WIDTH-1:0] step_val;

            assign units = cur[BCD_UNITS_LSB +: BCD_DIGIT_W];
            assign tens  = cur[BCD_TENS_LSB  +: BCD_DIGIT_W];

            always_comb begin
                step_val = cur;
                if (up_dn) begin
                    if (units == BCD_DIGIT_MAX) begin
                        step_val[BCD_UNITS_LSB +: BCD_DIGIT_W] = 4'd0;
                        step_val[BCD_TENS_LSB  +: BCD_DIGIT_W] = tens + 4'd1;
                    end else begin
                        step_val[BCD_UNITS_LSB +: BCD_DIGIT_W] = units + 4'd1;
                    end
                end else begin
                    if (units == 4'd0) begin
                        step_val[BCD_UNITS_LSB +: BCD_DIGIT_W] = BCD_DIGIT_MAX;
                        step_val[BCD_TENS_LSB  +: BCD_DIGIT_W] = tens - 4'd1;
                    end else begin
                        step_val[BCD_UNITS_LSB +: BCD_DIGIT_W] = units - 4'd1;
                    end
                end
                nxt = at_term ? (up_dn ? '0 : max_enc) : step_val;
            end
        end else begin : g_bin
            assign nxt = at_term ? (up_dn ? '0 : max_enc)
                                 : (up_dn ? cur + WIDTH'(1) : cur - WIDTH'(1));
        end
    endgenerate

endmodule

// File: rtl/mod_time_counter.sv
// Modulo-(MAX+1) binary/BCD up/down counter with synchronous load, zero-latency
// terminal count for cascading, and a lap-capture register with valid/ack.
module mod_time_counter
    import mod_time_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX   = 99,
    parameter int BCD   = ENC_BINARY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             lap_req,
    input  logic             lap_ack,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             load_err,
    output logic [WIDTH-1:0] lap_val,
    output logic             lap_valid,
    output logic             lap_ovf
);

    localparam logic [WIDTH-1:0] MAX_ENC = WIDTH'(max_to_enc(MAX, BCD));

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] lap_val_reg, lap_val_next;
    logic             lap_valid_reg, lap_valid_next;
    logic             lap_ovf_reg, lap_ovf_next;
    logic             load_err_reg, load_err_next;
    logic [WIDTH-1:0] step_val;
    logic             at_term;
    logic             load_ok;

    mod_step #(
        .WIDTH (WIDTH),
        .BCD   (BCD)
    ) u_step (
        .cur     (count_reg),
        .up_dn   (up_dn),
        .max_enc (MAX_ENC),
        .nxt     (step_val),
        .at_term (at_term)
    );

    // A BCD value with both nibbles in 0..9 orders the same as its decimal value.
    generate
        if (BCD == ENC_BCD) begin : g_load_bcd
            assign load_ok = (load_val[BCD_UNITS_LSB +: BCD_DIGIT_W] <= BCD_DIGIT_MAX) &&
                             (load_val[BCD_TENS_LSB  +: BCD_DIGIT_W] <= BCD_DIGIT_MAX) &&
                             (load_val <= MAX_ENC);
        end else begin : g_load_bin
            assign load_ok = (load_val <= MAX_ENC);
        end
    endgenerate

    assign tc = enable & ~clear & ~load & at_term;

    always_comb begin
        count_next    = count_reg;
        load_err_next = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next    = load_ok ? load_val : '0;
            load_err_next = ~load_ok;
        end else if (enable) begin
            count_next = step_val;
        end
    end

    // Lap capture samples count_reg, i.e. the value before this cycle's update.
    always_comb begin
        lap_val_next   = lap_val_reg;
        lap_valid_next = lap_valid_reg;
        lap_ovf_next   = lap_ovf_reg;
        if (clear) begin
            lap_valid_next = 1'b0;
            lap_ovf_next   = 1'b0;
        end else if (lap_req) begin
            if (!lap_valid_reg || lap_ack) begin
                lap_val_next   = count_reg;
                lap_valid_next = 1'b1;
            end else begin
                lap_ovf_next = 1'b1;
            end
        end else if (lap_ack) begin
            lap_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            lap_val_reg   <= '0;
            lap_valid_reg <= 1'b0;
            lap_ovf_reg   <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            count_reg     <= count_next;
            lap_val_reg   <= lap_val_next;
            lap_valid_reg <= lap_valid_next;
            lap_ovf_reg   <= lap_ovf_next;
            load_err_reg  <= load_err_next;
        end
    end

    assign count     = count_reg;
    assign lap_val   = lap_val_reg;
    assign lap_valid = lap_valid_reg;
    assign lap_ovf   = lap_ovf_reg;
    assign load_err  = load_err_reg;

endmodule

// File: tb/tb_mod_time_counter.sv
// Bench for mod_time_counter: a BCD seconds stage (MAX=59) and a binary stage
// (MAX=99) checked against a decimal-value reference model.
module tb_mod_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      clear, enable, up_dn, load, lap_req, lap_ack;
    logic [1:0][7:0] load_val;
    logic [1:0][7:0] count, lap_val;
    logic [1:0]      tc, load_err, lap_valid, lap_ovf;

    mod_time_counter #(.WIDTH(8), .MAX(59), .BCD(1)) u_bcd (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]), .enable(enable[0]),
        .up_dn(up_dn[0]), .load(load[0]), .load_val(load_val[0]),
        .lap_req(lap_req[0]), .lap_ack(lap_ack[0]), .count(count[0]),
        .tc(tc[0]), .load_err(load_err[0]), .lap_val(lap_val[0]),
        .lap_valid(lap_valid[0]), .lap_ovf(lap_ovf[0])
    );

    mod_time_counter #(.WIDTH(8), .MAX(99), .BCD(0)) u_bin (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]), .enable(enable[1]),
        .up_dn(up_dn[1]), .load(load[1]), .load_val(load_val[1]),
        .lap_req(lap_req[1]), .lap_ack(lap_ack[1]), .count(count[1]),
        .tc(tc[1]), .load_err(load_err[1]), .lap_val(lap_val[1]),
        .lap_valid(lap_valid[1]), .lap_ovf(lap_ovf[1])
    );

    int   maxv [2] = '{59, 99};
    bit   isbcd[2] = '{1'b1, 1'b0};

    // Reference model: count held as a plain decimal value.
    int         mv      [2];
    logic [7:0] m_lap   [2];
    bit         m_lvalid[2];
    bit         m_ovf   [2];
    bit         m_err   [2];

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [7:0] enc(input int k, input int v);
        if (isbcd[k]) return 8'(((v / 10) * 16) + (v % 10));
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_count%0d", tag, k), count[k], enc(k, mv[k]));
            chk($sformatf("%s_lapval%0d", tag, k), lap_val[k], m_lap[k]);
            chk($sformatf("%s_lapvalid%0d", tag, k), {7'd0, lap_valid[k]}, {7'd0, m_lvalid[k]});
            chk($sformatf("%s_lapovf%0d", tag, k), {7'd0, lap_ovf[k]}, {7'd0, m_ovf[k]});
            chk($sformatf("%s_loaderr%0d", tag, k), {7'd0, load_err[k]}, {7'd0, m_err[k]});
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; m_lap[k] = 8'h00; m_lvalid[k] = 1'b0; m_ovf[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int hi, lo, val;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0;
            if (clear[k]) begin
                mv[k] = 0; m_lvalid[k] = 1'b0; m_ovf[k] = 1'b0;
            end else begin
                if (lap_req[k]) begin
                    if (!m_lvalid[k] || lap_ack[k]) begin
                        m_lap[k] = enc(k, mv[k]); m_lvalid[k] = 1'b1;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end else if (lap_ack[k]) begin
                    m_lvalid[k] = 1'b0;
                end
                if (load[k]) begin
                    if (isbcd[k]) begin
                        hi  = int'(load_val[k][7:4]);
                        lo  = int'(load_val[k][3:0]);
                        val = hi * 10 + lo;
                        ok  = (hi <= 9) && (lo <= 9) && (val <= maxv[k]);
                    end else begin
                        val = int'(load_val[k]);
                        ok  = (val <= maxv[k]);
                    end
                    mv[k]    = ok ? val : 0;
                    m_err[k] = !ok;
                end else if (enable[k]) begin
                    mv[k] = up_dn[k] ? (mv[k] + 1) % (maxv[k] + 1)
                                     : (mv[k] + maxv[k]) % (maxv[k] + 1);
                end
            end
        end
    endtask

    // Drive stage d for one clock (the other stage idles), check tc before the
    // edge and all registered outputs after it. Starts and ends on a negedge.
    task automatic cycle(input int d, input logic clr, input logic en, input logic ud,
                         input logic ld, input logic [7:0] lv, input logic lr,
                         input logic la, input string tag);
        bit exp_tc;
        clear = '0; enable = '0; load = '0; lap_req = '0; lap_ack = '0; load_val = '0;
        clear[d] = clr; enable[d] = en; up_dn[d] = ud; load[d] = ld;
        load_val[d] = lv; lap_req[d] = lr; lap_ack[d] = la;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_tc = enable[k] && !clear[k] && !load[k] &&
                     (up_dn[k] ? (mv[k] == maxv[k]) : (mv[k] == 0));
            chk($sformatf("%s_tc%0d", tag, k), {7'd0, tc[k]}, {7'd0, exp_tc});
        end
        @(posedge clk);
        model_step();
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        int d;
        logic [7:0] rv;
        rst_n = 1'b0;
        clear = '0; enable = '0; up_dn = '1; load = '0; lap_req = '0; lap_ack = '0;
        load_val = '0;
        model_reset();
        #2;
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // BCD up-count through a full 60-step cycle
        for (int i = 0; i < 60; i++) begin
            cycle(0, 0, 1, 1, 0, 8'h00, 0, 0, "t1_up");
            if (i == 9)  chk("t1_0x10", count[0], 8'h10);
            if (i == 58) chk("t1_0x59", count[0], 8'h59);
        end
        chk("t1_wrap", count[0], 8'h00);

        // Binary down from 0 wraps to 99, then reverse direction
        cycle(1, 0, 1, 0, 0, 8'h00, 0, 0, "t2_down");
        chk("t2_99", count[1], 8'd99);
        cycle(1, 0, 1, 0, 0, 8'h00, 0, 0, "t2_down");
        chk("t2_98", count[1], 8'd98);
        cycle(1, 0, 1, 1, 0, 8'h00, 0, 0, "t2_up");
        cycle(1, 0, 1, 1, 0, 8'h00, 0, 0, "t2_up");
        chk("t2_0", count[1], 8'd0);

        // BCD load validation
        cycle(0, 0, 1, 1, 0, 8'h00, 0, 0, "t3_pre");
        cycle(0, 0, 0, 1, 1, 8'h4A, 0, 0, "t3_bad_nib");
        chk("t3_err1", {7'd0, load_err[0]}, 8'd1);
        cycle(0, 0, 0, 1, 1, 8'h60, 0, 0, "t3_bad_max");
        cycle(0, 0, 0, 1, 0, 8'h00, 0, 0, "t3_idle");
        chk("t3_err0", {7'd0, load_err[0]}, 8'd0);
        cycle(0, 0, 0, 1, 1, 8'h45, 0, 0, "t3_ok");
        chk("t3_45", count[0], 8'h45);
        cycle(0, 0, 0, 1, 1, 8'h59, 0, 0, "t3_59");
        cycle(0, 0, 1, 1, 1, 8'h12, 0, 0, "t3_load_en");
        chk("t3_12", count[0], 8'h12);

        // Lap handshake
        cycle(0, 0, 0, 1, 1, 8'h23, 0, 0, "t4_ld23");
        cycle(0, 0, 0, 1, 0, 8'h00, 1, 0, "t4_lap1");
        chk("t4_lap23", lap_val[0], 8'h23);
        cycle(0, 0, 1, 1, 0, 8'h00, 1, 0, "t4_lap_drop");
        chk("t4_ovf", {7'd0, lap_ovf[0]}, 8'd1);
        cycle(0, 0, 0, 1, 1, 8'h30, 0, 0, "t4_ld30");
        cycle(0, 0, 0, 1, 0, 8'h00, 1, 1, "t4_b2b");
        chk("t4_lap30", lap_val[0], 8'h30);
        cycle(0, 0, 0, 1, 0, 8'h00, 0, 1, "t4_ack");
        chk("t4_valid0", {7'd0, lap_valid[0]}, 8'd0);

        // Clear beats lap_req
        cycle(0, 0, 0, 1, 1, 8'h42, 0, 0, "t5_ld42");
        cycle(0, 0, 0, 1, 0, 8'h00, 1, 0, "t5_lap");
        cycle(0, 1, 1, 1, 0, 8'h00, 1, 0, "t5_clear");
        chk("t5_lapkeep", lap_val[0], 8'h42);

        // Randomized traffic on both stages
        for (int i = 0; i < 600; i++) begin
            d  = i % 2;
            rv = ($urandom_range(0, 1) == 1) ? enc(d, int'($urandom_range(0, maxv[d])))
                                             : 8'($urandom_range(0, 255));
            cycle(d, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0, rv,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, "rnd");
        end

        // Asynchronous reset mid-count with no clock edge
        cycle(0, 0, 0, 1, 1, 8'h37, 1, 1, "t6_ld");
        cycle(1, 0, 0, 1, 1, 8'd64, 1, 1, "t6_ld");
        cycle(0, 0, 1, 1, 0, 8'h00, 1, 1, "t6_run");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 1, 1, 0, 8'h00, 0, 0, "t6_after");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mod_time_counter.md
Name: mod_time_counter

Overview:
Parametrised successor to the stopwatch seconds/minutes counters. It is a modulo-(MAX+1) counter with binary or 2-digit BCD encoding, up/down direction, synchronous load and a combinational terminal-count output, so stages cascade without extra latency. A lap-capture register with a valid/ack handshake lets the display or UART path sample the count without stalling it.

Parameters:
WIDTH, 8, count/load/lap width in bits; must be 8 when BCD=1.
MAX, 99, terminal value in decimal; legal range 1..2^WIDTH-1 (binary) or 1..99 (BCD).
BCD, 0, 0 = binary encoding; 1 = two BCD digits {tens[7:4], units[3:0]}.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous clear of count, lap_valid and lap_ovf.
enable  in  1  count one step this cycle.
up_dn  in  1  1 = count up, 0 = count down.
load  in  1  synchronous load of load_val.
load_val  in  WIDTH  value to load, in the active encoding.
lap_req  in  1  capture the current count into lap_val.
lap_ack  in  1  consumer has taken lap_val.
count  out  WIDTH  current count, registered.
tc  out  1  terminal count/carry, combinational.
load_err  out  1  one-cycle pulse: rejected load_val.
lap_val  out  WIDTH  captured count, registered.
lap_valid  out  1  lap_val holds unconsumed data.
lap_ovf  out  1  sticky: a lap_req was dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: count=0, lap_val=0, lap_valid=0, lap_ovf=0, load_err=0.
- MAX_ENC is computed at elaboration: MAX (binary) or {MAX/10, MAX%10} (BCD).
- Count update priority, highest first: rst_n > clear > load > enable. Otherwise count holds.
- clear: count <= 0, lap_valid <= 0, lap_ovf <= 0. lap_val is unchanged.
- load, valid value: count <= load_val next cycle.
  - Binary: valid when load_val <= MAX.
  - BCD: valid when each nibble is <= 9 and the decimal value is <= MAX.
- load, invalid value: count <= 0 and load_err = 1 for exactly the following cycle.
- enable, up (up_dn=1): count==MAX_ENC -> 0; otherwise +1.
  - BCD: units 9 -> 0 with tens+1; otherwise units+1.
- enable, down (up_dn=0): count==0 -> MAX_ENC; otherwise -1.
  - BCD: units 0 -> 9 with tens-1; otherwise units-1.
- tc = enable & ~clear & ~load & (up_dn ? count==MAX_ENC : count==0).
  - Same cycle as the wrap edge, zero latency, for cascading into the next stage's enable.
- Direction change takes effect on the next enabled step with no extra cycle. tc follows up_dn combinationally.
- Lap capture samples the count as registered at that edge, i.e. before this cycle's update:
  - lap_req & ~lap_valid: lap_val <= count, lap_valid <= 1.
  - lap_req & lap_valid & lap_ack: lap_val <= count, lap_valid stays 1 (back-to-back).
  - lap_req & lap_valid & ~lap_ack: lap_val unchanged, lap_ovf <= 1 (sticky until clear/rst_n).
  - ~lap_req & lap_ack: lap_valid <= 0.
  - lap_ack with lap_valid=0 is ignored.
- clear and lap_req in the same cycle: clear wins, so lap_valid=0 after the edge.
- load and enable in the same cycle: load wins, tc=0.
- Asserting rst_n mid-count forces all outputs to their reset values immediately, without waiting for clk.
- All outputs except tc are registered. count latency is 1 cycle from enable/load/clear.

Decomposition:
- Shared stopwatch package/header holds:
  - BCD_DIGIT_MAX=9 and the BCD nibble positions.
  - The encoding-select constants used by the BCD parameter.
  - Default MAX values for seconds (59) and minutes (99) stages.
- One combinational sub-module, mod_step: inputs cur, up_dn, MAX_ENC, BCD; outputs next value and the at-terminal flag.
  - Shared by the up and down paths and reusable by a future hours stage.
- Load validation and lap handshake stay in mod_time_counter.

Test Plan:
1. BCD=1, MAX=59, up, enable held from 0x00: count 0x09 -> 0x10; 0x59 -> 0x00 with tc=1 only on the 0x59 cycle; 60 steps return to 0x00.
2. BCD=0, MAX=99, down from reset with enable: count 0 -> 99 and tc=1 on that edge; next value 98; toggle up_dn at 98 -> 99 -> 0 with tc=1.
3. BCD=1, MAX=59, load_val=0x4A -> count=0x00, load_err=1 for one cycle. load_val=0x60 -> same. load_val=0x45 -> count=0x45, load_err=0. load with enable set -> count=load_val, tc=0.
4. Lap handshake at count=0x23: lap_req -> lap_val=0x23, lap_valid=1. Second lap_req with no ack -> lap_val stays 0x23, lap_ovf=1. lap_req+lap_ack at count=0x30 -> lap_val=0x30, lap_valid=1. lap_ack alone -> lap_valid=0.
5. clear with lap_req at count=0x42 and lap_valid=1 -> count=0, lap_valid=0, lap_ovf=0, lap_val unchanged. Then drop rst_n mid-count with no clk edge -> all outputs 0 immediately.
